// File: rtl/store_rmw_ctrl_pkg.sv
// Shared types and constants for the store read-modify-write sequencer.
package store_rmw_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } state_e;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    localparam logic [1:0] SEL_SW = 2'd0;
    localparam logic [1:0] SEL_SH = 2'd1;
    localparam logic [1:0] SEL_SB = 2'd2;

    // sd and illegal widths never use the merge result, so they fall back to SEL_SW.
    function automatic logic [1:0] f3_to_sel(input logic [2:0] f3);
        logic [1:0] sel;
        case (f3)
            F3_SB:   sel = SEL_SB;
            F3_SH:   sel = SEL_SH;
            default: sel = SEL_SW;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// Request, data-memory and merge-stage signals of the store RMW sequencer.
interface store_rmw_ctrl_if;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [63:0] mem_addr;
    logic        mem_wr;
    logic [63:0] mem_rdata;
    logic [63:0] mem_wdata;
    logic [63:0] rmw_mem;
    logic [63:0] rmw_alt;
    logic [1:0]  rmw_sel;
    logic [63:0] merged;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  start, funct3, addr, store_data, mem_rdata, merged,
        output mem_addr, mem_wr, mem_wdata, rmw_mem, rmw_alt, rmw_sel, busy, done, err
    );

    modport master (
        output start, funct3, addr, store_data, mem_rdata, merged,
        input  mem_addr, mem_wr, mem_wdata, rmw_mem, rmw_alt, rmw_sel, busy, done, err
    );
endinterface

// File: rtl/store_rmw_ctrl.sv
// Multicycle read-modify-write sequencer for sb/sh/sw/sd; sd skips the read.
module store_rmw_ctrl
    import store_rmw_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    store_rmw_ctrl_if.slave  bus
);

    localparam int unsigned CntW = $clog2(READ_LAT + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     alt_q, alt_d;
    logic [63:0]     mem_q, mem_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      sel_q, sel_d;
    logic            err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            alt_q   <= '0;
            mem_q   <= '0;
            f3_q    <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            alt_q   <= alt_d;
            mem_q   <= mem_d;
            f3_q    <= f3_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        alt_d   = alt_q;
        mem_d   = mem_q;
        f3_d    = f3_q;
        sel_d   = sel_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d = bus.addr;
                    alt_d  = bus.store_data;
                    f3_d   = bus.funct3;
                    sel_d  = f3_to_sel(bus.funct3);
                    // Any width off a doubleword boundary is rejected before touching memory.
                    if (bus.funct3[2] || (bus.addr[2:0] != 3'b000)) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (bus.funct3 == F3_SD) begin
                        err_d   = 1'b0;
                        state_d = StWr;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = CntW'(READ_LAT - 1);
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (cnt_q == '0) begin
                    mem_d   = bus.mem_rdata;
                    state_d = StWr;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWr:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.mem_wr    = (state_q == StWr);
    assign bus.done      = (state_q == StDone);
    assign bus.err       = (state_q == StDone) && err_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = (state_q != StWr) ? '0 : ((f3_q == F3_SD) ? alt_q : bus.merged);
    assign bus.rmw_mem   = mem_q;
    assign bus.rmw_alt   = alt_q;
    assign bus.rmw_sel   = sel_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: three instances (READ_LAT 1/3/4) share stimulus, memory models per DUT.
module tb_store_rmw_ctrl;
    import store_rmw_pkg::*;

    logic        clk;
    logic        reset;
    logic        load_mem;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;

    logic [2:0]        busy_v, wr_v, done_v, err_v;
    logic [2:0][63:0]  maddr_v, wdata_v, rmem_v, alt_v;
    logic [2:0][1:0]   sel_v;

    logic [63:0] init_mem [512];
    logic [63:0] memm [512];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural merge stage sitting beside the sequencer.
    function automatic logic [63:0] merge_f(input logic [63:0] m, input logic [63:0] a,
                                            input logic [1:0] sel);
        case (sel)
            2'd0:    return {m[63:32], a[31:0]};
            2'd1:    return {m[63:16], a[15:0]};
            2'd2:    return {m[63:8], a[7:0]};
            default: return m;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        store_rmw_ctrl_if bus_if ();
        logic [63:0] mem [512];

        store_rmw_ctrl #(.READ_LAT(Lat)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus_if)
        );

        always @(posedge clk) begin
            if (load_mem) begin
                for (int i = 0; i < 512; i++) mem[i] <= init_mem[i];
            end else if (bus_if.mem_wr) begin
                mem[bus_if.mem_addr[11:3]] <= bus_if.mem_wdata;
            end
        end

        assign bus_if.start      = start;
        assign bus_if.funct3     = funct3;
        assign bus_if.addr       = addr;
        assign bus_if.store_data = store_data;
        assign bus_if.mem_rdata  = mem[bus_if.mem_addr[11:3]];
        assign bus_if.merged     = merge_f(bus_if.rmw_mem, bus_if.rmw_alt, bus_if.rmw_sel);

        assign busy_v[g]  = bus_if.busy;
        assign wr_v[g]    = bus_if.mem_wr;
        assign done_v[g]  = bus_if.done;
        assign err_v[g]   = bus_if.err;
        assign maddr_v[g] = bus_if.mem_addr;
        assign wdata_v[g] = bus_if.mem_wdata;
        assign rmem_v[g]  = bus_if.rmw_mem;
        assign alt_v[g]   = bus_if.rmw_alt;
        assign sel_v[g]   = bus_if.rmw_sel;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    function automatic logic [63:0] flags(input int g);
        return {60'b0, busy_v[g], wr_v[g], done_v[g], err_v[g]};
    endfunction

    task automatic check_zero(input string tag);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s flags L%0d", tag, lat_of(g)), flags(g), 64'h0);
            check($sformatf("%s mem_addr L%0d", tag, lat_of(g)), maddr_v[g], 64'h0);
            check($sformatf("%s mem_wdata L%0d", tag, lat_of(g)), wdata_v[g], 64'h0);
            check($sformatf("%s rmw_mem L%0d", tag, lat_of(g)), rmem_v[g], 64'h0);
            check($sformatf("%s rmw_alt L%0d", tag, lat_of(g)), alt_v[g], 64'h0);
            check($sformatf("%s rmw_sel L%0d", tag, lat_of(g)), {62'b0, sel_v[g]}, 64'h0);
        end
    endtask

    // One request; inputs are scrambled after the sampling edge and start is optionally re-pulsed
    // only while every instance is still busy.
    task automatic op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sdat,
                      input bit rep, input bit use_w, input logic [63:0] w_exp);
        bit          rej;
        int          idx, nb, dmin, wr_n, done_n, lat;
        logic [63:0] old, newv;
        logic [3:0]  ef;
        rej  = f3[2] || (a[2:0] != 3'b000);
        idx  = int'(a[11:3]);
        old  = memm[idx];
        newv = old;
        nb   = 1 << f3[1:0];
        for (int b = 0; b < 8; b++) if (b < nb) newv[8*b +: 8] = sdat[8*b +: 8];
        dmin = rej ? 1 : ((f3 == F3_SD) ? 2 : 3);

        @(negedge clk);
        start = 1'b1; funct3 = f3; addr = a; store_data = sdat;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                lat = lat_of(g);
                if (rej) begin wr_n = 0; done_n = 1; end
                else if (f3 == F3_SD) begin wr_n = 1; done_n = 2; end
                else begin wr_n = lat + 1; done_n = lat + 2; end
                ef = {n <= done_n, n == wr_n, n == done_n, rej && (n == done_n)};
                check($sformatf("flags L%0d n%0d f3=%0d", lat, n, f3), flags(g), {60'b0, ef});
                if (!rej && n <= wr_n)
                    check($sformatf("mem_addr L%0d n%0d", lat, n), maddr_v[g], a);
                if (n == wr_n) begin
                    check($sformatf("wdata L%0d", lat), wdata_v[g], newv);
                    if (use_w) check($sformatf("wdata_directed L%0d", lat), wdata_v[g], w_exp);
                end
                if (!rej && n == done_n) begin
                    check($sformatf("rmw_alt L%0d", lat), alt_v[g], sdat);
                    if (f3 != F3_SD) begin
                        check($sformatf("rmw_sel L%0d", lat), {62'b0, sel_v[g]},
                              64'(2 - int'(f3)));
                        check($sformatf("rmw_mem L%0d", lat), rmem_v[g], old);
                    end
                end
            end
            start      = rep && (n <= dmin);
            funct3     = 3'($urandom);
            addr       = {$urandom, $urandom};
            store_data = {$urandom, $urandom};
        end
        start = 1'b0;
        if (!rej) memm[idx] = newv;
    endtask

    task automatic reset_mid();
        @(negedge clk);
        start = 1'b1; funct3 = F3_SB; addr = 64'h100; store_data = 64'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int g = 0; g < 3; g++)
            check($sformatf("rd_before_reset L%0d", lat_of(g)), flags(g), 64'h8);
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++)
                check($sformatf("post_reset L%0d n%0d", lat_of(g), n), flags(g), 64'h0);
        end
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [63:0] ra;
        int          r;
        reset = 1'b1; load_mem = 1'b1; start = 1'b0;
        funct3 = '0; addr = '0; store_data = '0;
        for (int i = 0; i < 512; i++) init_mem[i] = {$urandom, $urandom};
        init_mem[32] = 64'h1122334455667788;
        init_mem[64] = 64'h0123456789ABCDEF;
        for (int i = 0; i < 512; i++) memm[i] = init_mem[i];
        repeat (2) @(posedge clk);
        @(negedge clk);
        load_mem = 1'b0;
        check_zero("reset");
        reset = 1'b0;

        op(F3_SB, 64'h100, 64'hAB, 1'b0, 1'b1, 64'h11223344556677AB);
        op(F3_SH, 64'h100, 64'hBEEF, 1'b0, 1'b1, 64'h112233445566BEEF);
        op(F3_SW, 64'h100, 64'hCAFEF00D, 1'b1, 1'b1, 64'h11223344CAFEF00D);
        op(F3_SD, 64'h200, 64'hDEADBEEF00000001, 1'b1, 1'b1, 64'hDEADBEEF00000001);
        op(3'b100, 64'h100, 64'h1234, 1'b1, 1'b0, 64'h0);
        op(F3_SW, 64'h104, 64'h5678, 1'b1, 1'b0, 64'h0);
        op(F3_SB, 64'h108, 64'h77, 1'b1, 1'b0, 64'h0);
        reset_mid();
        op(F3_SB, 64'h100, 64'h3C, 1'b0, 1'b1, 64'h11223344CAFEF03C);

        for (int i = 0; i < 40; i++) begin
            r   = int'($urandom_range(0, 9));
            rf3 = (r < 8) ? {1'b0, 2'(r)} : {1'b1, 2'(r)};
            ra  = {$urandom, 20'h0, 9'($urandom_range(0, 511)), 3'b000};
            if ($urandom_range(0, 7) == 0) ra[2:0] = 3'($urandom_range(1, 7));
            op(rf3, ra, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
